// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the MEM stage and the data
// memory. Stores are queued and drained one per cycle whenever no load is
// using the memory port. Loads read the youngest matching queued store,
// falling back to memory read data when nothing matches.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  input  logic [7:0]              st_addr,
  input  logic [7:0]              st_data,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_addr,
  output logic [7:0]              ld_data,
  output logic                    stall,
  output logic                    mem_writeEn,
  output logic [7:0]              mem_address,
  output logic [7:0]              mem_writeData,
  input  logic [7:0]              mem_readData,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage: it is never reset, so stale contents stay behind after a
  // reset. Only the pointers and the count decide which slots are live.
  logic [7:0]    r_addr [DEPTH];
  logic [7:0]    r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_drain;

  // Status comes only from registered state, so inputs cannot glitch it.
  // A drain in the same cycle does not free a slot for the incoming store.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = st_valid && !w_full;
  assign w_drain = !w_empty && !ld_valid;

  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;
  assign stall = st_valid && w_full;

  // Pointer and occupancy update. Enqueue and drain in the same cycle move
  // both pointers and leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write the accepted store into the tail slot.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
  end

  // Memory port: a load owns the port; otherwise the head entry drains;
  // when idle the address follows ld_addr and the write data is zero.
  always_comb begin
    mem_writeEn   = 1'b0;
    mem_address   = ld_addr;
    mem_writeData = 8'h00;
    if (w_drain) begin
      mem_writeEn   = 1'b1;
      mem_address   = r_addr[r_head];
      mem_writeData = r_data[r_head];
    end
  end

  // Load forwarding: walk the live entries from oldest to youngest so the
  // last hit (the youngest store to that address) wins. A store arriving in
  // this same cycle is not in the buffer yet and therefore never forwards.
  always_comb begin
    ld_data = mem_readData;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && (r_addr[r_head + PW'(k)] == ld_addr)) begin
        ld_data = r_data[r_head + PW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table plus hand-written sequences for
// wrap-around and asynchronous reset in the middle of draining.
module tb_store_buffer;

  logic       clk;
  logic       rst;
  logic       st_valid;
  logic [7:0] st_addr;
  logic [7:0] st_data;
  logic       ld_valid;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       stall;
  logic       mem_writeEn;
  logic [7:0] mem_address;
  logic [7:0] mem_writeData;
  logic [7:0] mem_readData;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int errors;
  int checks;

  store_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .stall        (stall),
    .mem_writeEn  (mem_writeEn),
    .mem_address  (mem_address),
    .mem_writeData(mem_writeData),
    .mem_readData (mem_readData),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  // Memory model: combinational read returns address XOR A5.
  localparam logic [7:0] RD_KEY = 8'hA5;
  assign mem_readData = mem_address ^ RD_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sv;
    logic [7:0] sa;
    logic [7:0] sd;
    logic       lv;
    logic [7:0] la;
    logic       chk_ld;
    logic [7:0] ld;
    logic       stall;
    logic       we;
    logic [7:0] ma;
    logic [7:0] wd;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sv, input logic [7:0] sa, input logic [7:0] sd,
                     input logic lv, input logic [7:0] la,
                     input logic chk_ld, input logic [7:0] ld,
                     input logic stl, input logic we, input logic [7:0] ma,
                     input logic [7:0] wd, input logic [2:0] cnt,
                     input logic fl, input logic em);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
    v.chk_ld = chk_ld; v.ld = ld; v.stall = stl; v.we = we; v.ma = ma;
    v.wd = wd; v.cnt = cnt; v.full = fl; v.empty = em;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [7:0] sa, input logic [7:0] sd,
                       input logic lv, input logic [7:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

    // Basic store and load miss
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 0, 8'h00,  8'h00, 3'd0, 0, 1);
    add(0, 8'h00, 8'h00, 1, 8'd100,  1, 8'd100 ^ 8'hA5,    0, 0, 8'd100, 8'h00, 3'd0, 0, 1);
    add(1, 8'd50, 8'h2A, 0, 8'h00,   0, 8'h00,             0, 0, 8'h00,  8'h00, 3'd0, 0, 1);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'd50,  8'h2A, 3'd1, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 0, 8'h00,  8'h00, 3'd0, 0, 1);
    // Forwarding: youngest of two stores to 60; same-cycle store not forwarded
    add(1, 8'd60, 8'h11, 1, 8'd60,   1, 8'd60 ^ 8'hA5,     0, 0, 8'd60,  8'h00, 3'd0, 0, 1);
    add(1, 8'd60, 8'h22, 1, 8'd60,   1, 8'h11,             0, 0, 8'd60,  8'h00, 3'd1, 0, 0);
    add(0, 8'h00, 8'h00, 1, 8'd60,   1, 8'h22,             0, 0, 8'd60,  8'h00, 3'd2, 0, 0);
    add(0, 8'h00, 8'h00, 1, 8'd60,   1, 8'h22,             0, 0, 8'd60,  8'h00, 3'd2, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'd60,  8'h11, 3'd2, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'd60,  8'h22, 3'd1, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 0, 8'h00,  8'h00, 3'd0, 0, 1);
    // Full and stall under a held load, then in-order drain
    add(1, 8'h10, 8'hA0, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd0, 0, 1);
    add(1, 8'h11, 8'hA1, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd1, 0, 0);
    add(1, 8'h12, 8'hA2, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd2, 0, 0);
    add(1, 8'h13, 8'hA3, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd3, 0, 0);
    add(1, 8'h14, 8'hA4, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     1, 0, 8'h70,  8'h00, 3'd4, 1, 0);
    add(1, 8'h14, 8'hA4, 1, 8'h12,   1, 8'hA2,             1, 0, 8'h12,  8'h00, 3'd4, 1, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'h10,  8'hA0, 3'd4, 1, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'h11,  8'hA1, 3'd3, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'h12,  8'hA2, 3'd2, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'h13,  8'hA3, 3'd1, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 0, 8'h00,  8'h00, 3'd0, 0, 1);
    // Full with a drain: still stalls; then enqueue and drain together
    add(1, 8'h20, 8'hB0, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd0, 0, 1);
    add(1, 8'h21, 8'hB1, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd1, 0, 0);
    add(1, 8'h22, 8'hB2, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd2, 0, 0);
    add(1, 8'h23, 8'hB3, 1, 8'h70,   1, 8'h70 ^ 8'hA5,     0, 0, 8'h70,  8'h00, 3'd3, 0, 0);
    add(1, 8'h24, 8'hB4, 0, 8'h00,   0, 8'h00,             1, 1, 8'h20,  8'hB0, 3'd4, 1, 0);
    add(1, 8'h24, 8'hB4, 0, 8'h00,   0, 8'h00,             0, 1, 8'h21,  8'hB1, 3'd3, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'h22,  8'hB2, 3'd3, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'h23,  8'hB3, 3'd2, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 1, 8'h24,  8'hB4, 3'd1, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00,   0, 8'h00,             0, 0, 8'h00,  8'h00, 3'd0, 0, 1);

    // Reset state
    #12;
    check("reset_count", {5'b0, count}, 8'd0);
    check("reset_empty", {7'b0, empty}, 8'd1);
    check("reset_full",  {7'b0, full},  8'd0);
    check("reset_we",    {7'b0, mem_writeEn}, 8'd0);
    check("reset_stall", {7'b0, stall}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].lv, vecs[i].la);
      @(negedge clk);
      $display("vec %0d: sv=%b sa=%h sd=%h lv=%b la=%h -> ld=%h stall=%b we=%b ma=%h wd=%h cnt=%0d",
               i, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].lv, vecs[i].la,
               ld_data, stall, mem_writeEn, mem_address, mem_writeData, count);
      if (vecs[i].chk_ld) check($sformatf("v%0d_ld_data", i), ld_data, vecs[i].ld);
      check($sformatf("v%0d_stall", i), {7'b0, stall}, {7'b0, vecs[i].stall});
      check($sformatf("v%0d_we", i),    {7'b0, mem_writeEn}, {7'b0, vecs[i].we});
      check($sformatf("v%0d_addr", i),  mem_address, vecs[i].ma);
      check($sformatf("v%0d_wdata", i), mem_writeData, vecs[i].wd);
      check($sformatf("v%0d_count", i), {5'b0, count}, {5'b0, vecs[i].cnt});
      check($sformatf("v%0d_full", i),  {7'b0, full},  {7'b0, vecs[i].full});
      check($sformatf("v%0d_empty", i), {7'b0, empty}, {7'b0, vecs[i].empty});
    end

    // Wrap-around: ten back-to-back stores, each drained the cycle after
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk);
      #1;
      drive(i < 10, 8'(100 + i), 8'(8'hC0 + i), 1'b0, 8'h00);
      @(negedge clk);
      $display("wrap %0d: we=%b ma=%h wd=%h cnt=%0d", i, mem_writeEn, mem_address, mem_writeData, count);
      if (i == 0) begin
        check("wrap0_we", {7'b0, mem_writeEn}, 8'd0);
        check("wrap0_count", {5'b0, count}, 8'd0);
      end else begin
        check($sformatf("wrap%0d_we", i),    {7'b0, mem_writeEn}, 8'd1);
        check($sformatf("wrap%0d_addr", i),  mem_address, 8'(100 + i - 1));
        check($sformatf("wrap%0d_wdata", i), mem_writeData, 8'(8'hC0 + i - 1));
        check($sformatf("wrap%0d_count", i), {5'b0, count}, 8'd1);
      end
    end
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    check("wrap_end_empty", {7'b0, empty}, 8'd1);
    check("wrap_end_we", {7'b0, mem_writeEn}, 8'd0);

    // Mid-drain asynchronous reset
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 8'(8'h30 + k), 8'(8'hD0 + k), 1'b1, 8'h70);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    $display("pre-reset: we=%b ma=%h wd=%h cnt=%0d", mem_writeEn, mem_address, mem_writeData, count);
    check("prerst_we", {7'b0, mem_writeEn}, 8'd1);
    check("prerst_addr", mem_address, 8'h30);
    check("prerst_count", {5'b0, count}, 8'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    st_valid = 1'b1;
    #1;
    $display("async reset: cnt=%0d empty=%b we=%b stall=%b", count, empty, mem_writeEn, stall);
    check("arst_count", {5'b0, count}, 8'd0);
    check("arst_empty", {7'b0, empty}, 8'd1);
    check("arst_full",  {7'b0, full},  8'd0);
    check("arst_we",    {7'b0, mem_writeEn}, 8'd0);
    check("arst_stall", {7'b0, stall}, 8'd0);
    st_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d_we", k), {7'b0, mem_writeEn}, 8'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("post-reset %0d: we=%b empty=%b", k, mem_writeEn, empty);
      check($sformatf("postrst%0d_we", k), {7'b0, mem_writeEn}, 8'd0);
      check($sformatf("postrst%0d_empty", k), {7'b0, empty}, 8'd1);
    end
    // Normal operation resumes after reset
    @(posedge clk);
    #1;
    drive(1'b1, 8'h40, 8'hEE, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    $display("resume: we=%b ma=%h wd=%h cnt=%0d", mem_writeEn, mem_address, mem_writeData, count);
    check("resume_we", {7'b0, mem_writeEn}, 8'd1);
    check("resume_addr", mem_address, 8'h40);
    check("resume_wdata", mem_writeData, 8'hEE);
    check("resume_count", {5'b0, count}, 8'd1);
    @(negedge clk);
    check("resume_empty", {7'b0, empty}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
- REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
- REQ-004 SHALL have port st_valid, input, 1, a store from the MEM stage is presented this cycle.
- REQ-005 SHALL have port st_addr, input, 8, the store address.
- REQ-006 SHALL have port st_data, input, 8, the store data.
- REQ-007 SHALL have port ld_valid, input, 1, a load from the MEM stage is presented this cycle.
- REQ-008 SHALL have port ld_addr, input, 8, the load address.
- REQ-009 SHALL have port ld_data, output, 8, the load result (forwarded or memory).
- REQ-010 SHALL have port stall, output, 1, the store is not accepted and the pipeline must hold.
- REQ-011 SHALL have port mem_writeEn, output, 1, the data memory write enable.
- REQ-012 SHALL have port mem_address, output, 8, the data memory address.
- REQ-013 SHALL have port mem_writeData, output, 8, the data memory write data.
- REQ-014 SHALL have port mem_readData, input, 8, the data memory combinational read data.
- REQ-015 SHALL have ports count (output, clog2(DEPTH)+1 bits, occupied entries), full (output, 1) and empty (output, 1).

Function
- REQ-016 SHALL hold an in-order FIFO of DEPTH {addr, data} entries with head/tail pointers that wrap modulo DEPTH.
- REQ-017 SHALL define full = (count == DEPTH) and empty = (count == 0), both registered-state derived, no glitch from inputs.
- REQ-018 SHALL enqueue {st_addr, st_data} at tail on the clock edge when st_valid and not full.
- REQ-019 SHALL drive stall = st_valid and full, combinationally; a stalled store is not enqueued and is re-presented by upstream.
- REQ-020 SHALL drain when not empty and ld_valid is 0: mem_writeEn=1, mem_address=head addr, mem_writeData=head data; head advances at the edge.
- REQ-021 SHALL give the load priority: when ld_valid=1, mem_writeEn=0, mem_address=ld_addr, and no drain occurs that cycle.
- REQ-022 SHALL drive mem_address=ld_addr, mem_writeEn=0 and mem_writeData=0 when neither draining nor loading.
- REQ-023 SHALL drive ld_data from the youngest buffer entry whose addr equals ld_addr, else mem_readData; combinational, zero-cycle latency.
- REQ-024 SHALL exclude the entry being drained in the same cycle from forwarding only after the edge (no drain occurs during a load, so there is no conflict).
- REQ-025 SHALL, on simultaneous enqueue and drain, leave count unchanged while both pointers advance.
- REQ-026 SHALL not treat a same-cycle drain as freeing space: stall is asserted whenever full, even if a drain occurs.
- REQ-027 SHALL, when st_valid and ld_valid are both 1, accept the store and exclude it from that cycle's forwarding.
- REQ-028 SHALL keep a store's latency to memory at 1 cycle minimum (enqueue edge, drain in the following cycle).

Reset
- REQ-029 SHALL, while rst=1, immediately clear head, tail and count, giving empty=1, full=0, mem_writeEn=0 and stall=0.
- REQ-030 SHALL discard buffered entries on reset mid-operation; undrained stores are lost and entry storage is not cleared.
- REQ-031 SHALL resume normal operation on the first rising clk after rst deasserts.

Verification
- REQ-032 SHALL verify basic store: store (50, 8'h2A), no loads -> count=1 next cycle; the following cycle mem_writeEn=1, addr 50, data 2A; then empty=1.
- REQ-033 SHALL verify forwarding: enqueue (60, 11) then (60, 22), hold ld_valid with ld_addr=60 -> ld_data=22, mem_writeEn=0, count stays 2.
- REQ-034 SHALL verify full/stall with DEPTH=4: four stores while ld_valid=1 -> full=1; a fifth store -> stall=1 and count stays 4; drop ld_valid -> drains in order over 4 cycles.
- REQ-035 SHALL verify wrap-around: enqueue and drain 10 stores to addresses 100..109 -> memory writes appear in order with correct data and pointers wrap.
- REQ-036 SHALL verify a load miss: empty buffer, ld_addr=100 -> ld_data equals mem_readData and mem_address=100.
- REQ-037 SHALL verify mid-drain reset: 3 entries, assert rst asynchronously between edges -> count=0, empty=1 and mem_writeEn=0 immediately, with no further writes.
